advance_module: RTL
===================

// Module: advance_module
// PURPOSE
//  - Inverse of the KPN delay stage: consumes and discards the first ADVANCE_NUMBER tokens on a
//    16-bit channel, then forwards every later token unchanged.
//  - Placed where the XML compiler cancels a delay, i.e. strips the initial zero tokens that a
//    delay stage injected upstream.
//  - Both sides use a valid/ready handshake. A 2-entry skid buffer on the output side decouples
//    backpressure.
// PARAMETERS
//  - ADVANCE_NUMBER  0  tokens to discard after reset (0..65535; 0 = pure pass-through buffer)
// PORTS
//  - clk             in   1   rising-edge clock
//  - reset           in   1   synchronous, active-high reset
//  - entry_1         in   16  input token data
//  - entry_1_valid   in   1   input token present
//  - entry_1_ready   out  1   module accepts the token this cycle
//  - output_1        out  16  output token data
//  - output_1_valid  out  1   output token present
//  - output_1_ready  in   1   downstream accepts the token this cycle
//  - skip_done       out  1   high once all ADVANCE_NUMBER tokens have been discarded
// BEHAVIOUR
//  - Transfers: an input transfer occurs when entry_1_valid & entry_1_ready at a posedge; an
//    output transfer when output_1_valid & output_1_ready.
//  - Reset values: output_1=16'h0000, output_1_valid=0, skid empty, skip count=0,
//    skip_done=(ADVANCE_NUMBER==0). entry_1_ready is 1 the cycle after reset.
//  - Reset mid-operation: tokens held in the buffers are dropped and the skip count restarts.
//    Reset has priority over every other event.
//  - FSM states:
//    - SKIP
//      - Entered from reset if ADVANCE_NUMBER>0.
//      - entry_1_ready=1 and output_1_valid=0.
//      - Each input transfer increments the 16-bit count. Data is ignored.
//      - The transfer that brings count to ADVANCE_NUMBER moves to PASS and sets skip_done the
//        next cycle. That token is also discarded.
//    - PASS
//      - Entered from reset if ADVANCE_NUMBER==0, or from SKIP as above.
//      - Terminal until reset.
//  - PASS datapath: main output register (out) plus one skid register (skd).
//    - entry_1_ready = !skd_valid, driven from a register (no combinational path from
//      output_1_ready).
//    - Input transfer with out empty, or out being drained this cycle: token goes to out.
//    - Input transfer with out full and not draining: token goes to skd.
//    - Output transfer with skd full: skd moves to out and skd empties.
//    - Order is preserved. No token is duplicated or lost.
//  - Latency: 1 cycle from input transfer to output_1_valid when the buffer is empty.
//    Throughput is 1 token/cycle while output_1_ready=1.
//  - Full (skd_valid=1): entry_1_ready=0. Any entry_1 presented is not consumed.
//  - Simultaneous input and output transfer with out full and skd empty: out takes the new token
//    and skd stays empty.
//  - output_1 holds its last value when output_1_valid=0. It is never X after reset.
//  - Data is not modified: no arithmetic, width 16 end to end.
// CONFIGURATION
//  - ADVANCE_CHECK_ZERO_EN
//    - Defined: adds output port skip_error (1 bit, reset 0). It is sticky-set the cycle after
//      any discarded token is non-zero, flagging a mismatched delay. It clears only on reset.
//    - Undefined: the port and its logic are absent, and discarded data is never examined.
//  - Pass-through behaviour is identical either way.
// TESTING
//  - ADVANCE_NUMBER=3, output_1_ready=1, feed 0,0,0,5,6,7 back-to-back:
//    - output_1 = 5,6,7 on consecutive cycles, each 1 cycle after its input.
//    - skip_done rises the cycle after the 3rd token.
//  - ADVANCE_NUMBER=0, feed 16'hA5A5: output_1_valid=1 with 16'hA5A5 one cycle later and
//    skip_done=1 from reset.
//  - PASS, output_1_ready=0, feed 1,2,3:
//    - 1 and 2 are accepted, then entry_1_ready=0 and 3 is held.
//    - Raise ready: outputs 1,2,3 in order with no loss.
//  - Alternate output_1_ready every cycle while streaming 100 random tokens: the output sequence
//    equals the input sequence exactly.
//  - Assert reset after 2 of 4 skip tokens:
//    - outputs clear to reset values.
//    - 4 fresh tokens are then discarded before the first forward.
//  - With ADVANCE_CHECK_ZERO_EN and ADVANCE_NUMBER=2, feed 0,16'h0001,9:
//    - skip_error=1 from the cycle after the 2nd token and stays set.
//    - output_1 = 9.

Source files
------------

// File: rtl/advance_module.sv
// advance_module: discards the first ADVANCE_NUMBER tokens after reset, then forwards the rest
// through a 2-entry (out + skid) buffer. Optional macro ADVANCE_CHECK_ZERO_EN adds skip_error.
module advance_module #(
   parameter int unsigned ADVANCE_NUMBER = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] entry_1,
   input  logic        entry_1_valid,
   output logic        entry_1_ready,
   output logic [15:0] output_1,
   output logic        output_1_valid,
   input  logic        output_1_ready,
   output logic        skip_done
`ifdef ADVANCE_CHECK_ZERO_EN
   ,
   output logic        skip_error
`endif
);

   typedef enum logic {
      ST_SKIP,
      ST_PASS
   } state_t;

   localparam state_t LP_RESET_STATE = (ADVANCE_NUMBER == 0) ? ST_PASS : ST_SKIP;
   localparam logic   LP_RESET_DONE  = (ADVANCE_NUMBER == 0);

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_cnt;
   logic        r_done;
   logic [15:0] r_out_data;
   logic        r_out_valid;
   logic [15:0] r_skd_data;
   logic        r_skd_valid;

   logic        w_in_xfer;
   logic        w_out_xfer;
   logic        w_last_skip;
   logic        w_cnt_inc;
   logic        w_done_set;
   logic        w_out_load_in;
   logic        w_out_load_skd;
   logic        w_out_clear;
   logic        w_skd_load;
   logic        w_skd_clear;

   // Ready depends only on the skid register, so no combinational path from output_1_ready.
   assign entry_1_ready  = ~r_skd_valid;
   assign output_1       = r_out_data;
   assign output_1_valid = r_out_valid;
   assign skip_done      = r_done;

   assign w_in_xfer   = entry_1_valid & ~r_skd_valid;
   assign w_out_xfer  = r_out_valid & output_1_ready;
   assign w_last_skip = ((32'(r_cnt) + 32'd1) == ADVANCE_NUMBER);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LP_RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_inc      = 1'b0;
      w_done_set     = 1'b0;
      w_out_load_in  = 1'b0;
      w_out_load_skd = 1'b0;
      w_out_clear    = 1'b0;
      w_skd_load     = 1'b0;
      w_skd_clear    = 1'b0;
      case (r_state)
         ST_SKIP: begin
            if (w_in_xfer) begin
               w_cnt_inc = 1'b1;
               if (w_last_skip) begin
                  w_done_set  = 1'b1;
                  w_state_nxt = ST_PASS;
               end
            end
         end
         ST_PASS: begin
            if (w_out_xfer) begin
               if (r_skd_valid) begin
                  w_out_load_skd = 1'b1;
                  w_skd_clear    = 1'b1;
               end else if (w_in_xfer) begin
                  w_out_load_in = 1'b1;
               end else begin
                  w_out_clear = 1'b1;
               end
            end else if (w_in_xfer) begin
               if (r_out_valid) begin
                  w_skd_load = 1'b1;
               end else begin
                  w_out_load_in = 1'b1;
               end
            end
         end
         default: w_state_nxt = LP_RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_done      <= LP_RESET_DONE;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_skd_data  <= '0;
         r_skd_valid <= 1'b0;
      end else begin
         if (w_cnt_inc) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_done_set) begin
            r_done <= 1'b1;
         end
         if (w_out_load_skd) begin
            r_out_data  <= r_skd_data;
            r_out_valid <= 1'b1;
         end else if (w_out_load_in) begin
            r_out_data  <= entry_1;
            r_out_valid <= 1'b1;
         end else if (w_out_clear) begin
            r_out_valid <= 1'b0;
         end
         if (w_skd_load) begin
            r_skd_data  <= entry_1;
            r_skd_valid <= 1'b1;
         end else if (w_skd_clear) begin
            r_skd_valid <= 1'b0;
         end
      end
   end

`ifdef ADVANCE_CHECK_ZERO_EN
   logic r_err;

   assign skip_error = r_err;

   // A non-zero discarded token means the cancelled delay did not inject zeros.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if ((r_state == ST_SKIP) && w_in_xfer && (entry_1 != 16'h0000)) begin
         r_err <= 1'b1;
      end
   end
`endif

endmodule
